// File: rtl/mem_stage_cache.sv
// mem_stage_cache: two-way set-associative, write-through, no-allocate data
// cache between the MEM stage and the SRAM controller.
// Define CACHE_LRU_EN for per-set LRU replacement; otherwise a global toggle
// bit flipped on every fill picks the victim when both ways are valid.
module mem_stage_cache #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         read_en,
   input  logic                         write_en,
   input  logic [ADDR_W-1:0]            address,
   input  logic [DATA_W-1:0]            writeData,
   output logic [DATA_W-1:0]            readData,
   output logic                         ready,
   output logic                         mem_rd_req,
   output logic                         mem_wr_req,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [DATA_W-1:0]            mem_wdata,
   input  logic [LINE_WORDS*DATA_W-1:0] mem_rdata,
   input  logic                         mem_ready
);

   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int WSEL_W = (OFF_W > 0) ? OFF_W : 1;
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - 2 - OFF_W - IDX_W;
   localparam int LINE_W = LINE_WORDS * DATA_W;

   typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

   state_t state, next_state;

   logic [LINE_W-1:0] data_mem [2][SETS];
   logic [TAG_W-1:0]  tag_mem  [2][SETS];
   logic [SETS-1:0]   valid    [2];
`ifdef CACHE_LRU_EN
   logic [SETS-1:0]   lru;
`else
   logic              toggle;
`endif

   logic [WSEL_W-1:0] word_idx;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [1:0]        way_hit;
   logic              hit, hit_way, victim;
   logic [LINE_W-1:0] hit_line, merged_line;
   logic              fill_done, write_done, read_hit;
   logic              unused_byte_bits;

   // Byte offset is never used: the cache only handles whole words.
   assign unused_byte_bits = ^address[1:0];

   // With LINE_WORDS=1 the word field is empty; masking forces word 0.
   assign word_idx = address[2 +: WSEL_W] & WSEL_W'(LINE_WORDS - 1);
   assign idx      = address[2 + OFF_W +: IDX_W];
   assign tag      = address[ADDR_W-1 -: TAG_W];

   assign way_hit[0] = valid[0][idx] && (tag_mem[0][idx] == tag);
   assign way_hit[1] = valid[1][idx] && (tag_mem[1][idx] == tag);
   assign hit        = |way_hit;
   assign hit_way    = way_hit[1];
   assign hit_line   = data_mem[hit_way][idx];

   assign fill_done  = (state == FILL)  && mem_ready;
   assign write_done = (state == WRITE) && mem_ready;
   assign read_hit   = (state == IDLE) && read_en && !write_en && hit;

   // Victim: invalid way first (way0 preferred), else the replacement bit.
   always_comb begin
      if (!valid[0][idx])
         victim = 1'b0;
      else if (!valid[1][idx])
         victim = 1'b1;
      else
`ifdef CACHE_LRU_EN
         victim = lru[idx];
`else
         victim = toggle;
`endif
   end

   // Resident line with the store word substituted, for write hits.
   always_comb begin
      merged_line = hit_line;
      merged_line[word_idx*DATA_W +: DATA_W] = writeData;
   end

   // Load data from whichever way hits; zero when nothing hits.
   always_comb begin
      readData = '0;
      if (hit)
         readData = hit_line[word_idx*DATA_W +: DATA_W];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state, ready and SRAM request outputs; requests follow the state.
   always_comb begin
      next_state = state;
      ready      = 1'b0;
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      unique case (state)
         IDLE: begin
            if (write_en)
               next_state = WRITE;
            else if (read_en && !hit)
               next_state = FILL;
            else
               ready = 1'b1;
         end
         FILL: begin
            mem_rd_req = 1'b1;
            mem_addr   = address & ~ADDR_W'(LINE_WORDS*4 - 1);
            if (mem_ready)
               next_state = DONE;
         end
         WRITE: begin
            mem_wr_req = 1'b1;
            mem_addr   = address;
            mem_wdata  = writeData;
            if (mem_ready)
               next_state = DONE;
         end
         DONE: begin
            ready      = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Valid bits and replacement state; reset wins over any pending update.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid[0] <= '0;
         valid[1] <= '0;
`ifdef CACHE_LRU_EN
         lru      <= '0;
`else
         toggle   <= 1'b0;
`endif
      end else begin
         if (fill_done)
            valid[victim][idx] <= 1'b1;
`ifdef CACHE_LRU_EN
         if (fill_done)
            lru[idx] <= ~victim;
         else if (read_hit || (write_done && hit))
            lru[idx] <= ~hit_way;
`else
         if (fill_done)
            toggle <= ~toggle;
`endif
      end
   end

   // Tag and data arrays, not reset; updates suppressed while rst is high.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (fill_done) begin
            data_mem[victim][idx] <= mem_rdata;
            tag_mem[victim][idx]  <= tag;
         end else if (write_done && hit) begin
            data_mem[hit_way][idx] <= merged_line;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_cache.sv
// Directed bench for mem_stage_cache (SETS=64, LINE_WORDS=2, SRAM completes
// 3 cycles after the request cycle). Expected load data is queued at drive
// time and compared when ready rises. Define CACHE_LRU_EN for the LRU build.
module tb_mem_stage_cache;

   logic        clk = 1'b0;
   logic        rst, read_en, write_en, mem_ready;
   logic [31:0] address, writeData, readData, mem_addr, mem_wdata;
   logic        ready, mem_rd_req, mem_wr_req;
   logic [63:0] mem_rdata;

   int n_checks = 0;
   int n_err    = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   mem_stage_cache #(
      .ADDR_W(32), .DATA_W(32), .SETS(64), .LINE_WORDS(2)
   ) dut (
      .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
      .address(address), .writeData(writeData), .readData(readData),
      .ready(ready), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; read_en = 1'b0; write_en = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One pipeline request held until ready; SRAM answers in request cycle + 3.
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [63:0] line,
                         input logic memop, input logic [31:0] exp_data, input string tag);
      logic        done;
      logic [31:0] exp_rd;
      if (rd && !wr) exp_q.push_back(exp_data);
      @(negedge clk);
      read_en = rd; write_en = wr; address = addr; writeData = wdata;
      mem_rdata = line; mem_ready = 1'b0;
      done = 1'b0;
      for (int cyc = 0; cyc < 20 && !done; cyc++) begin
         #1;
         if (cyc == 0 && !memop)
            check({tag, ":no_req"}, {mem_rd_req, mem_wr_req}, 2'b00);
         if (cyc == 1 && memop) begin
            check({tag, ":req"}, {mem_rd_req, mem_wr_req}, wr ? 2'b01 : 2'b10);
            check({tag, ":mem_addr"}, mem_addr, wr ? addr : (addr & 32'hFFFF_FFF8));
            if (wr) check({tag, ":mem_wdata"}, mem_wdata, wdata);
         end
         if (ready) begin
            done = 1'b1;
            check({tag, ":latency"}, cyc, memop ? 4 : 0);
            if (rd && !wr) begin
               exp_rd = exp_q.pop_front();
               check({tag, ":data"}, readData, exp_rd);
            end
            if (memop) check({tag, ":req_off"}, {mem_rd_req, mem_wr_req}, 2'b00);
         end else begin
            mem_ready = (cyc == 3);
            @(negedge clk);
            mem_ready = 1'b0;
         end
      end
      if (!done) begin
         check({tag, ":timeout"}, done, 1'b1);
         if (rd && !wr) exp_rd = exp_q.pop_front();
      end
      read_en = 1'b0; write_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; read_en = 1'b0; write_en = 1'b0; mem_ready = 1'b0;
      address = '0; writeData = '0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst:ready", ready, 1'b1);
      check("rst:reqs", {mem_rd_req, mem_wr_req}, 2'b00);
      check("rst:mem_addr", mem_addr, 32'h0);
      check("rst:mem_wdata", mem_wdata, 32'h0);
      check("rst:readData", readData, 32'h0);

      // Fill, then same-line hit on the other word
      access(1, 0, 32'h400, 0, 64'h22222222_11111111, 1, 32'h11111111, "s1_fill");
      access(1, 0, 32'h404, 0, '0, 0, 32'h22222222, "s1_hit");

      // Store hit updates the cached word
      access(0, 1, 32'h400, 32'hDEADBEEF, '0, 1, 0, "s2_store");
      access(1, 0, 32'h400, 0, '0, 0, 32'hDEADBEEF, "s2_hit");

      // Store miss does not allocate
      access(0, 1, 32'h800, 32'h01234567, '0, 1, 0, "s3_store");
      access(1, 0, 32'h800, 0, 64'h44444444_33333333, 1, 32'h33333333, "s3_miss");
      access(1, 0, 32'h404, 0, '0, 0, 32'h22222222, "s3_hit_kept");

      // Replacement policy within set 0
      do_reset();
      access(1, 0, 32'h400, 0, 64'hA1A1A1A1_A0A0A0A0, 1, 32'hA0A0A0A0, "s4_fill400");
      access(1, 0, 32'h600, 0, 64'hB1B1B1B1_B0B0B0B0, 1, 32'hB0B0B0B0, "s4_fill600");
      access(1, 0, 32'h400, 0, '0, 0, 32'hA0A0A0A0, "s4_hit400");
      access(1, 0, 32'h800, 0, 64'hC1C1C1C1_C0C0C0C0, 1, 32'hC0C0C0C0, "s4_fill800");
`ifdef CACHE_LRU_EN
      access(1, 0, 32'h400, 0, '0, 0, 32'hA0A0A0A0, "s4_lru_keep400");
`else
      access(1, 0, 32'h400, 0, 64'hA1A1A1A1_A0A0A0A0, 1, 32'hA0A0A0A0, "s4_tog_evict400");
`endif

      // Reset mid-FILL, with a completion arriving on the same edge
      do_reset();
      @(negedge clk);
      read_en = 1'b1; address = 32'h400;
      @(negedge clk);
      #1;
      check("s5_in_fill", mem_rd_req, 1'b1);
      rst = 1'b1; read_en = 1'b0; mem_ready = 1'b1;
      mem_rdata = 64'hEEEEEEEE_DDDDDDDD;
      @(negedge clk);
      rst = 1'b0; mem_ready = 1'b0;
      #1;
      check("s5_req_off", {mem_rd_req, mem_wr_req}, 2'b00);
      check("s5_ready", ready, 1'b1);
      access(1, 0, 32'h400, 0, 64'h66666666_55555555, 1, 32'h55555555, "s5_refill");

      // Simultaneous read and write is a store
      access(1, 1, 32'h404, 32'hCAFEF00D, '0, 1, 0, "s6_rdwr");
      access(1, 0, 32'h404, 0, '0, 0, 32'hCAFEF00D, "s6_hit");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
